// File: rtl/riscv_zero_fetch.sv
// riscv_zero fetch stage: owns the PC, issues credit-limited in-order word
// fetches, buffers returned words with their PCs and hands them to decode.
// Redirects flush the buffer and discard every response still in flight.
module riscv_zero_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] pc_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;            // counters span 0..DEPTH
   localparam logic [CW-1:0] ONE_C   = 1;
   localparam logic [AW-1:0] ONE_A   = 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

   // architectural state
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   // buffer storage, no reset needed: occupancy is tracked by cnt_q
   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];

   logic [CW:0] credit_sum;
   logic        acc;
   logic        rsp_ok;
   logic        pop;
   logic        push;
   logic        unused_ok;

   // low target bits are forced to zero, so they carry no information
   assign unused_ok = ^redirect_pc[1:0];

   // credit uses registered counts only; a pop in the same cycle frees nothing yet
   assign credit_sum     = {1'b0, outst_q} + {1'b0, cnt_q};
   assign imem_req_valid = reset_n & (credit_sum < DEPTH_W);
   assign imem_req_addr  = pc_q;

   assign inst_valid = (cnt_q != '0);
   assign inst_data  = inst_valid ? inst_mem[rd_ptr_q] : 32'd0;
   assign pc_out     = inst_valid ? pc_mem[rd_ptr_q]   : 32'd0;

   assign acc    = imem_req_valid & imem_req_ready;
   // a response with nothing outstanding is a protocol error and is ignored
   assign rsp_ok = imem_rsp_valid & (outst_q != '0);
   assign pop    = inst_valid & inst_ready;

   // outstanding count: +1 per accepted request, -1 per honoured response
   always_comb begin
      outst_d = outst_q;
      if (acc && !rsp_ok) begin
         outst_d = outst_q + ONE_C;
      end else if (!acc && rsp_ok) begin
         outst_d = outst_q - ONE_C;
      end
   end

   // next-state for PC, drop counter and buffer; redirect overrides everything
   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      drop_d   = drop_q;
      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      push     = 1'b0;
      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         rsp_pc_d = {redirect_pc[31:2], 2'b00};
         // everything still in flight after this edge belongs to the old path
         drop_d   = outst_d;
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (acc) begin
            pc_d = pc_q + 32'd4;
         end
         if (rsp_ok) begin
            if (drop_q != '0) begin
               drop_d = drop_q - ONE_C;
            end else begin
               push     = 1'b1;
               rsp_pc_d = rsp_pc_q + 32'd4;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_A;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_A;
         end
         if (push && !pop) begin
            cnt_d = cnt_q + ONE_C;
         end else if (!push && pop) begin
            cnt_d = cnt_q - ONE_C;
         end
      end
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // buffer write: kept responses are stored with the PC they were fetched from
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= rsp_pc_q;
         inst_mem[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// Bench for riscv_zero_fetch: a default instance driven by a variable-latency
// memory with random handshakes, plus a DEPTH=4 instance starting near the top
// of the address space with an ideal 1-cycle memory.
module tb_riscv_zero_fetch;

   localparam int DEPTH = 2;
   localparam logic [31:0] W_RESET_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, pc_out;

   logic        w_req_valid, w_req_ready;
   logic [31:0] w_req_addr;
   logic        w_rsp_valid;
   logic [31:0] w_rsp_data;
   logic        w_redirect_valid;
   logic [31:0] w_redirect_pc;
   logic        w_inst_valid, w_inst_ready;
   logic [31:0] w_inst_data, w_pc_out;

   riscv_zero_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .pc_out(pc_out)
   );

   riscv_zero_fetch #(.RESET_PC(W_RESET_PC), .DEPTH(4)) u_wrap (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
      .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
      .inst_data(w_inst_data), .pc_out(w_pc_out)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // memory contents: a fixed scramble of the word address
   function automatic logic [31:0] fdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   typedef struct {
      logic [31:0] addr;
      longint      due;
      bit          stale;   // issued before a reset, DUT no longer counts it
   } req_t;

   req_t        mem_q[$];
   longint      cyc = 0;
   longint      last_due = 0;
   int          lat_min = 1, lat_max = 1;
   int          p_req = 100, p_inst = 100, p_redir = 0;  // p_redir per mille
   bit          force_reset = 1, force_redir = 0, hold_req = 0;
   logic [31:0] force_target = 32'h0;
   logic [31:0] exp_req_pc = 32'h0, exp_pop_pc = 32'h0;
   bit          prev_redir = 0, prev_stall = 0;
   logic [31:0] prev_tgt = 32'h0, held_pc = 32'h0, held_data = 32'h0;
   int          pops = 0;

   bit          w_acc_prev = 0, w_arm = 0, w_hit = 0, w_prev_redir = 0;
   logic [31:0] w_addr_prev = 32'h0;
   logic [31:0] w_exp_req = W_RESET_PC, w_exp_pop = W_RESET_PC;
   int          w_pops = 0;

   function automatic int live_count();
      int n = 0;
      foreach (mem_q[i]) if (!mem_q[i].stale) n++;
      return n;
   endfunction

   function automatic int stale_count();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].stale) n++;
      return n;
   endfunction

   // one clock cycle: drive inputs at the falling edge, check, update the model
   task automatic cycle();
      bit          rst, acc, pop, redir, w_acc, w_pop, w_redir;
      logic [31:0] tgt;
      int          live, lat;
      longint      due;
      req_t        ent;
      @(negedge clk);
      rst     = force_reset;
      reset_n = !rst;
      live    = live_count();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         ent = mem_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = fdata(ent.addr);
      end
      imem_req_ready = !rst && !hold_req && ($urandom_range(0, 99) < p_req);
      inst_ready     = ($urandom_range(0, 99) < p_inst);
      w_rsp_valid    = w_acc_prev;
      w_rsp_data     = fdata(w_addr_prev);
      w_req_ready    = 1'b1;
      w_inst_ready   = 1'b1;
      #1;
      acc   = (imem_req_valid === 1'b1) && imem_req_ready;
      pop   = (inst_valid === 1'b1) && inst_ready;
      w_acc = (w_req_valid === 1'b1);
      w_pop = (w_inst_valid === 1'b1);
      tgt   = $urandom & 32'h0000_3FFF;
      redir = 1'b0;
      if (!rst) begin
         if (force_redir) begin
            redir = 1'b1;
            tgt   = force_target;
         end else if ($urandom_range(0, 999) < p_redir) begin
            redir = 1'b1;
         end
      end
      redirect_valid = redir;
      redirect_pc    = redir ? tgt : $urandom;
      w_redir = !rst && w_arm && w_rsp_valid && w_acc && w_pop;
      w_redirect_valid = w_redir;
      w_redirect_pc    = 32'h0000_0302;

      if (!rst) begin
         if (prev_redir) begin
            chk("redir_flush", inst_valid, 1'b0);
            chk("redir_addr", imem_req_addr, {prev_tgt[31:2], 2'b00});
         end
         if (prev_stall) begin
            chk("hold_valid", inst_valid, 1'b1);
            chk("hold_pc", pc_out, held_pc);
            chk("hold_data", inst_data, held_data);
         end
         if (imem_req_valid === 1'b1) chk("credit", live < DEPTH, 1'b1);
         if (acc) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due, stale: 1'b0});
         end
         if (pop && !redir) begin
            chk("pc_out", pc_out, exp_pop_pc);
            chk("inst_data", inst_data, fdata(exp_pop_pc));
            exp_pop_pc = exp_pop_pc + 32'd4;
            pops++;
         end
         if (redir) begin
            exp_req_pc = {tgt[31:2], 2'b00};
            exp_pop_pc = {tgt[31:2], 2'b00};
         end
         prev_stall = (inst_valid === 1'b1) && !inst_ready && !redir;
         held_pc    = pc_out;
         held_data  = inst_data;

         if (w_prev_redir) begin
            chk("w_redir_flush", w_inst_valid, 1'b0);
            chk("w_redir_addr", w_req_addr, 32'h0000_0300);
         end
         if (w_acc) begin
            chk("w_req_addr", w_req_addr, w_exp_req);
            w_exp_req = w_exp_req + 32'd4;
         end
         if (w_pop && !w_redir) begin
            chk("w_pc_out", w_pc_out, w_exp_pop);
            chk("w_inst_data", w_inst_data, fdata(w_exp_pop));
            w_exp_pop = w_exp_pop + 32'd4;
            w_pops++;
         end
         if (w_redir) begin
            w_exp_req = 32'h0000_0300;
            w_exp_pop = 32'h0000_0300;
            w_hit     = 1'b1;
            w_arm     = 1'b0;
         end
      end else begin
         exp_req_pc = 32'h0;
         exp_pop_pc = 32'h0;
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         prev_stall = 1'b0;
         w_exp_req  = W_RESET_PC;
         w_exp_pop  = W_RESET_PC;
      end
      prev_redir   = redir;
      prev_tgt     = tgt;
      w_prev_redir = w_redir;
      w_acc_prev   = w_acc;
      w_addr_prev  = w_req_addr;
      cyc++;
   endtask

   initial begin
      int  n0, w0;
      bit  found;
      reset_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
      w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_inst_ready = 1'b0;

      // reset held for several cycles: outputs at their reset values
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (i > 0) begin
            chk("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_req_addr", imem_req_addr, 32'h0);
            chk("rst_inst_valid", inst_valid, 1'b0);
            chk("rst_inst_data", inst_data, 32'h0);
            chk("rst_pc_out", pc_out, 32'h0);
            chk("w_rst_req_addr", w_req_addr, W_RESET_PC);
         end
      end

      // startup with 1-cycle memory and decode always ready
      force_reset = 0;
      cycle();
      chk("start_req_valid", imem_req_valid, 1'b1);
      chk("start_addr_c0", imem_req_addr, 32'h0);
      cycle();
      chk("start_valid_c1", inst_valid, 1'b0);
      chk("start_addr_c1", imem_req_addr, 32'h4);
      cycle();
      chk("start_valid_c2", inst_valid, 1'b1);
      chk("start_pc_c2", pc_out, 32'h0);
      n0 = pops;
      repeat (20) cycle();
      chk("stream_rate", (pops - n0) >= 9, 1'b1);

      // decode stalls: buffer fills, credit runs out, head holds
      p_inst = 0;
      repeat (5) cycle();
      chk("stall_req_valid", imem_req_valid, 1'b0);
      chk("stall_inst_valid", inst_valid, 1'b1);
      p_inst = 100;
      repeat (10) cycle();

      // redirect to 0x100 with two requests outstanding on a 3-cycle memory
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (live_count() == 2) found = 1;
      end
      chk("wait_two_outstanding", found, 1'b1);
      force_redir = 1; force_target = 32'h0000_0100;
      cycle();
      force_redir = 0;
      n0 = pops;
      repeat (20) cycle();
      chk("redir100_progress", (pops - n0) >= 2, 1'b1);

      // misaligned redirect target
      lat_min = 1; lat_max = 1;
      force_redir = 1; force_target = 32'h0000_0203;
      cycle();
      force_redir = 0;
      cycle();
      chk("redir203_addr", imem_req_addr, 32'h0000_0200);
      repeat (8) cycle();

      // redirect coinciding with response, accept and pop (DEPTH=4 instance)
      w_arm = 1;
      for (int i = 0; i < 20 && !w_hit; i++) cycle();
      chk("combo_hit", w_hit, 1'b1);
      w0 = w_pops;
      repeat (8) cycle();
      chk("combo_progress", (w_pops - w0) >= 2, 1'b1);

      // one-cycle reset mid-stream with two requests outstanding
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle();
         if (live_count() == 2) found = 1;
      end
      chk("wait_two_before_reset", found, 1'b1);
      force_reset = 1;
      cycle();
      force_reset = 0;
      hold_req = 1;
      cycle();
      chk("mid_rst_inst_valid", inst_valid, 1'b0);
      chk("mid_rst_inst_data", inst_data, 32'h0);
      chk("mid_rst_pc_out", pc_out, 32'h0);
      chk("mid_rst_req_addr", imem_req_addr, 32'h0);
      chk("mid_rst_req_valid", imem_req_valid, 1'b1);
      for (int i = 0; i < 20 && stale_count() != 0; i++) cycle();
      chk("stale_drained", stale_count() == 0, 1'b1);
      hold_req = 0;
      n0 = pops;
      repeat (20) cycle();
      chk("restart_progress", (pops - n0) >= 2, 1'b1);

      // randomized traffic: handshakes, latencies and redirects
      lat_min = 1; lat_max = 4;
      p_req = 70; p_inst = 70; p_redir = 25;
      n0 = pops;
      repeat (3000) cycle();
      chk("random_progress", (pops - n0) > 200, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
